// File: rtl/rf_scoreboard_pkg.sv
// Shared constants and WB->ID bus layout for the register scoreboard.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rf_scoreboard_pkg;

    localparam int GPR_NUM     = 32;
    localparam int WBB_W       = 38;
    localparam int WBB_WE      = 37;
    localparam int WBB_ADDR_HI = 36;
    localparam int WBB_ADDR_LO = 32;
    localparam int CNT_W_DEF   = 2;

    // WB commit bus as seen by ID; field order matches the raw 38-bit bus.
    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } wb_bus_t;

endpackage

// File: rtl/rf_scoreboard_sb_counter.sv
// Saturating up/down pending-write counter for one GPR.
// Latency: 1 cycle from inc/dec/clr to cnt; sat/nonzero/ovf reflect the registered count.
// Backpressure: none; increments at max are held and flagged on ovf, decrements at zero are held.
module sb_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sat,
    output logic         nonzero,
    output logic         ovf
);

    localparam logic [W-1:0] CNT_MAX = '1;

    assign sat     = (cnt == CNT_MAX);
    assign nonzero = |cnt;
    // A paired inc/dec is a no-op, so it cannot overflow; a clear drops the increment.
    assign ovf     = inc & ~dec & ~clr & sat;

    // Count in-flight writes; clear dominates, and both ends saturate instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc && !dec && !sat) begin
            cnt <= cnt + W'(1);
        end else if (dec && !inc && nonzero) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/rf_scoreboard.sv
// Register-hazard scoreboard beside ID: tracks in-flight GPR writes and stalls dependent reads.
// Latency: issue visible on busy_vec/id_stall next cycle; with RETIRE_BYPASS a WB retire frees the stall same cycle.
// Backpressure: id_stall is combinational from registered counts and WB bus only (never from issue_fire).
module rf_scoreboard
    import rf_scoreboard_pkg::*;
#(
    parameter int CNT_W         = CNT_W_DEF,
    parameter bit RETIRE_BYPASS = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               issue_fire,
    input  logic               issue_we,
    input  logic [4:0]         issue_dest,
    input  logic [WBB_W-1:0]   wb_id_bus,
    input  logic               flush,
    input  logic               rj_en,
    input  logic [4:0]         rj,
    input  logic               rk_en,
    input  logic [4:0]         rk,
    input  logic               id_dest_we,
    input  logic [4:0]         id_dest,
    output logic               id_stall,
    output logic [GPR_NUM-1:0] busy_vec,
    output logic               sat_err
);

    wb_bus_t            wb;
    logic               inc;
    logic               ret;
    logic [4:0]         ret_addr;
    logic [GPR_NUM-1:0] eff_busy_vec;
    logic [GPR_NUM-1:0] sat_vec;
    logic [GPR_NUM-1:0] ovf_vec;
    logic               unused_wdata;

    assign wb       = wb_id_bus;
    assign ret_addr = wb.rf_waddr;
    assign inc      = issue_fire & issue_we & (issue_dest != 5'd0);
    assign ret      = wb.rf_we & (wb.rf_waddr != 5'd0);
    // Write data is consumed by the register file, not by the bookkeeping.
    assign unused_wdata = ^wb.rf_wdata;

    // r0 is hardwired: never pending, never saturated.
    assign busy_vec[0]     = 1'b0;
    assign eff_busy_vec[0] = 1'b0;
    assign sat_vec[0]      = 1'b0;
    assign ovf_vec[0]      = 1'b0;

    for (genvar i = 1; i < GPR_NUM; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt;
        logic             hit_inc;
        logic             hit_ret;

        assign hit_inc = inc & (issue_dest == 5'(i));
        assign hit_ret = ret & (ret_addr == 5'(i));

        sb_counter #(.W(CNT_W)) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .inc     (hit_inc),
            .dec     (hit_ret),
            .clr     (flush),
            .cnt     (cnt),
            .sat     (sat_vec[i]),
            .nonzero (busy_vec[i]),
            .ovf     (ovf_vec[i])
        );

        // A retire of the last pending write clears the read hazard this cycle when bypassing.
        assign eff_busy_vec[i] = busy_vec[i] &
                                 ~(RETIRE_BYPASS & hit_ret & (cnt == CNT_W'(1)));
    end

    // Hold ID while a source has an outstanding write or the destination counter is full.
    always_comb begin
        id_stall = 1'b0;
        if (rj_en && rj != 5'd0 && eff_busy_vec[rj]) begin
            id_stall = 1'b1;
        end
        if (rk_en && rk != 5'd0 && eff_busy_vec[rk]) begin
            id_stall = 1'b1;
        end
        if (id_dest_we && id_dest != 5'd0 && sat_vec[id_dest]) begin
            id_stall = 1'b1;
        end
    end

    // Sticky overflow flag; survives flush, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_err <= 1'b0;
        end else if (|ovf_vec) begin
            sat_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard: directed scenarios then randomized traffic against a count model.
// Latency: outputs compared mid-cycle against the model state for the current inputs.
// Backpressure: stimulus ignores id_stall so hazards and saturation are exercised.
module tb_rf_scoreboard;

    localparam int CNT_W   = 2;
    localparam bit BYPASS  = 1'b1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_fire;
    logic        issue_we;
    logic [4:0]  issue_dest;
    logic [37:0] wb_id_bus;
    logic        flush;
    logic        rj_en;
    logic [4:0]  rj;
    logic        rk_en;
    logic [4:0]  rk;
    logic        id_dest_we;
    logic [4:0]  id_dest;
    logic        id_stall;
    logic [31:0] busy_vec;
    logic        sat_err;

    int n_chk = 0;
    int n_err = 0;

    // Reference state: pending-write count per GPR plus the sticky error.
    int m_cnt [32];
    bit m_sat;

    rf_scoreboard #(.CNT_W(CNT_W), .RETIRE_BYPASS(BYPASS)) dut (
        .clk        (clk),
        .reset      (reset),
        .issue_fire (issue_fire),
        .issue_we   (issue_we),
        .issue_dest (issue_dest),
        .wb_id_bus  (wb_id_bus),
        .flush      (flush),
        .rj_en      (rj_en),
        .rj         (rj),
        .rk_en      (rk_en),
        .rk         (rk),
        .id_dest_we (id_dest_we),
        .id_dest    (id_dest),
        .id_stall   (id_stall),
        .busy_vec   (busy_vec),
        .sat_err    (sat_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int eff(input int a);
        int c;
        c = m_cnt[a];
        if (BYPASS && wb_id_bus[37] && wb_id_bus[36:32] != 5'd0 &&
            int'(wb_id_bus[36:32]) == a && c > 0) begin
            c = c - 1;
        end
        return c;
    endfunction

    function automatic logic model_stall();
        logic s;
        s = 1'b0;
        if (rj_en && rj != 5'd0 && eff(int'(rj)) != 0) s = 1'b1;
        if (rk_en && rk != 5'd0 && eff(int'(rk)) != 0) s = 1'b1;
        if (id_dest_we && id_dest != 5'd0 && m_cnt[id_dest] == CNT_MAX) s = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        b = '0;
        for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] != 0);
        return b;
    endfunction

    task automatic model_step();
        bit inc_m;
        bit ret_m;
        int d;
        int ra;
        if (reset) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            m_sat = 1'b0;
            return;
        end
        d     = int'(issue_dest);
        ra    = int'(wb_id_bus[36:32]);
        inc_m = issue_fire && issue_we && d != 0;
        ret_m = wb_id_bus[37] && ra != 0;
        if (flush) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        end else if (inc_m && ret_m && d == ra) begin
            // paired issue/retire leaves the count alone
        end else begin
            if (inc_m) begin
                if (m_cnt[d] == CNT_MAX) m_sat = 1'b1;
                else m_cnt[d]++;
            end
            if (ret_m && m_cnt[ra] > 0) m_cnt[ra]--;
        end
    endtask

    task automatic clear_inputs();
        reset      = 1'b0;
        issue_fire = 1'b0;
        issue_we   = 1'b0;
        issue_dest = 5'd0;
        wb_id_bus  = '0;
        flush      = 1'b0;
        rj_en      = 1'b0;
        rj         = 5'd0;
        rk_en      = 1'b0;
        rk         = 5'd0;
        id_dest_we = 1'b0;
        id_dest    = 5'd0;
    endtask

    // One clock: compare against the model mid-cycle, then advance the model at the edge.
    task automatic cycle();
        @(negedge clk);
        if (!reset) begin
            check("stall_model", 32'(id_stall), 32'(model_stall()));
            check("busy_model", busy_vec, model_busy());
            check("sat_model", 32'(sat_err), 32'(m_sat));
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic issue(input logic [4:0] d);
        clear_inputs();
        issue_fire = 1'b1;
        issue_we   = 1'b1;
        issue_dest = d;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        model_step();
        #1;
        clear_inputs();

        // Reset state with a read of r5.
        rj_en = 1'b1; rj = 5'd5; #1;
        check("rst_stall", 32'(id_stall), 32'd0);
        check("rst_busy", busy_vec, 32'd0);
        check("rst_sat", 32'(sat_err), 32'd0);
        cycle();

        // Issue r5, then dependent read until WB retires it.
        issue(5'd5); cycle();
        clear_inputs(); rj_en = 1'b1; rj = 5'd5; #1;
        check("dep_busy5", 32'(busy_vec[5]), 32'd1);
        check("dep_stall", 32'(id_stall), 32'd1);
        cycle();
        clear_inputs(); rj_en = 1'b1; rj = 5'd5; cycle();
        clear_inputs(); rj_en = 1'b1; rj = 5'd5;
        wb_id_bus = {1'b1, 5'd5, 32'hdead_beef}; #1;
        check("bypass_stall", 32'(id_stall), 32'd0);
        check("bypass_busy5", 32'(busy_vec[5]), 32'd1);
        cycle();
        clear_inputs(); rj_en = 1'b1; rj = 5'd5; #1;
        check("ret_busy5", 32'(busy_vec[5]), 32'd0);
        cycle();

        // r0 is never tracked.
        issue(5'd0); wb_id_bus = {1'b1, 5'd0, 32'h0}; rk_en = 1'b1; rk = 5'd0; #1;
        check("r0_stall", 32'(id_stall), 32'd0);
        cycle();
        #1; check("r0_busy", busy_vec, 32'd0);

        // Same-register issue and retire in one cycle.
        issue(5'd7); cycle();
        issue(5'd7); wb_id_bus = {1'b1, 5'd7, 32'h1}; cycle();
        #1; check("same_busy7", 32'(busy_vec[7]), 32'd1);
        clear_inputs(); wb_id_bus = {1'b1, 5'd7, 32'h2}; cycle();
        #1; check("same_clr7", 32'(busy_vec[7]), 32'd0);

        // Saturate r9 and overflow it.
        repeat (3) begin issue(5'd9); cycle(); end
        clear_inputs(); id_dest_we = 1'b1; id_dest = 5'd9; #1;
        check("sat_stall", 32'(id_stall), 32'd1);
        check("sat_noerr", 32'(sat_err), 32'd0);
        cycle();
        issue(5'd9); cycle();
        #1; check("sat_err", 32'(sat_err), 32'd1);
        clear_inputs(); id_dest_we = 1'b1; id_dest = 5'd9; #1;
        check("sat_held", 32'(id_stall), 32'd1);
        cycle();

        // Flush drops all bookkeeping, including a concurrent issue.
        issue(5'd3); cycle();
        issue(5'd3); cycle();
        issue(5'd4); cycle();
        issue(5'd3); flush = 1'b1; cycle();
        #1; check("flush_busy", busy_vec, 32'd0);
        check("flush_sat_kept", 32'(sat_err), 32'd1);
        clear_inputs(); wb_id_bus = {1'b1, 5'd3, 32'h3}; rj_en = 1'b1; rj = 5'd3; cycle();
        #1; check("flush_ret_busy", busy_vec, 32'd0);

        // Randomized traffic over a small register window to force collisions.
        for (int n = 0; n < 3000; n++) begin
            clear_inputs();
            reset      = ($urandom_range(0, 299) == 0);
            issue_fire = ($urandom_range(0, 1) == 1);
            issue_we   = ($urandom_range(0, 3) != 0);
            issue_dest = 5'($urandom_range(0, 7));
            wb_id_bus  = {($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), 32'($urandom())};
            flush      = ($urandom_range(0, 59) == 0);
            rj_en      = ($urandom_range(0, 3) != 0);
            rj         = 5'($urandom_range(0, 7));
            rk_en      = ($urandom_range(0, 1) == 1);
            rk         = 5'($urandom_range(0, 7));
            id_dest_we = ($urandom_range(0, 1) == 1);
            id_dest    = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Register-hazard scheduler for the 5-stage in-order pipeline (IF/ID/EX/MEM/WB); sits beside the ID stage.
- Keeps a per-register count of in-flight writes: incremented when a writing instruction leaves ID, decremented when WB commits via the 38-bit WB->ID bus.
- Drives the ID-stage stall so an instruction never reads a GPR with an outstanding write.
- Flush port clears all tracking on pipeline cancel.

Parameters:
- CNT_W, 2, width of each per-register pending counter; maximum in-flight writes per register is 2^CNT_W-1.
- RETIRE_BYPASS, 1, 1 = a WB retire in the current cycle is credited to the stall decision combinationally; 0 = stall is based on registered counts only.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- issue_fire  in  1  ID->EX handshake completes this cycle (id_valid & ex_allowin & id_ready_go)
- issue_we  in  1  issuing instruction writes a GPR
- issue_dest  in  5  destination GPR of the issuing instruction
- wb_id_bus  in  38  WB commit bus {rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}; only bits 37:32 are used
- flush  in  1  cancel all in-flight instructions younger than WB
- rj_en  in  1  ID instruction reads rj
- rj  in  5  rj address
- rk_en  in  1  ID instruction reads rk/rd (second source)
- rk  in  5  second source address
- id_dest_we  in  1  ID instruction will write a GPR
- id_dest  in  5  ID instruction destination
- id_stall  out  1  ID must hold (forces id_ready_go low)
- busy_vec  out  32  bit i = GPR i has a pending write
- sat_err  out  1  sticky: an increment was attempted on a saturated counter

Behaviour:
- State: cnt[1..31], each CNT_W bits. cnt[0] does not exist; GPR r0 is never busy. busy_vec[0] = 0.
- Reset: all cnt = 0; sat_err = 0. Outputs after reset: id_stall = 0, busy_vec = 0.
- inc = issue_fire & issue_we & (issue_dest != 0).
- ret = wb_id_bus[37] & (wb_id_bus[36:32] != 0); ret_addr = wb_id_bus[36:32].
- Per-cycle counter update, registered at posedge clk:
  - inc only: cnt[issue_dest] + 1.
  - ret only: cnt[ret_addr] - 1.
  - inc and ret to the same register: count unchanged.
  - inc and ret to different registers: each updated independently.
- Retire on a zero counter: the counter is held at 0 (no wrap). This can only occur after a flush, where WB commits an instruction issued before the flush; that is legal.
- Increment on a counter at 2^CNT_W-1: the counter is held and sat_err is set. id_stall normally prevents this case.
- flush: at the next edge all cnt = 0, regardless of concurrent inc/ret; flush dominates. An instruction already in WB still commits its write; only the bookkeeping is dropped. sat_err is not cleared by flush.
- eff_cnt[a]: equals cnt[a], except when RETIRE_BYPASS=1 and ret & ret_addr==a, in which case it is cnt[a] - 1 (floored at 0).
- id_stall, combinational:
  - (rj_en & rj!=0 & eff_cnt[rj]!=0)
  - | (rk_en & rk!=0 & eff_cnt[rk]!=0)
  - | (id_dest_we & id_dest!=0 & cnt[id_dest]==2^CNT_W-1)
- id_stall does not depend on issue_fire, so there is no combinational loop through ex_allowin.
- busy_vec[i] = (cnt[i] != 0), registered counts only, no bypass.
- Latency: an issue is visible in busy_vec/id_stall one cycle after issue_fire. With RETIRE_BYPASS=1 a retire releases the stall in the same cycle.

Decomposition:
- Shared package holds:
  - GPR_NUM = 32.
  - WB bus field positions WBB_WE = 37, WBB_ADDR_HI = 36, WBB_ADDR_LO = 32, WBB_W = 38.
  - CNT_W default.
- One natural sub-module, sb_counter: a single saturating up/down counter with inc, dec, clr, sat flag, and nonzero output. It is instantiated 31 times in a generate loop. The top level does address decode, bypass and stall logic.

Test Plan:
- Reset, then read checks: hold reset 2 cycles; drive rj_en=1, rj=5 -> id_stall=0, busy_vec=0, sat_err=0.
- Issue then dependent read: issue_fire=1, issue_we=1, issue_dest=5 at cycle T -> busy_vec[5]=1 at T+1; rj=5, rj_en=1 -> id_stall=1. wb_id_bus[37:32]={1,5} at T+3 -> id_stall=0 in T+3 with RETIRE_BYPASS=1, or in T+4 with RETIRE_BYPASS=0; busy_vec[5]=0 at T+4.
- r0 immunity: issue dest=0 and retire addr=0 -> busy_vec stays 0; rk=0, rk_en=1 -> id_stall=0.
- Simultaneous issue/retire same register: cnt[7]=1, then issue dest=7 and retire 7 in the same cycle -> cnt[7] stays 1, busy_vec[7]=1. Retire 7 the next cycle -> busy_vec[7]=0.
- Saturation: with CNT_W=2, issue dest=9 three times -> cnt=3; id_dest_we=1, id_dest=9 -> id_stall=1. Force a fourth issue_fire -> cnt stays 3, sat_err=1 (sticky).
- Flush: cnt[3]=2, cnt[4]=1, flush=1 together with issue dest=3 -> all counts 0 next cycle, busy_vec=0. A subsequent retire of 3 -> cnt[3] stays 0, no error.
